mode_stack: RTL and testbench
=============================

# mode_stack

Parametrised LIFO/FIFO buffer: the next-generation storage block for the control path, replacing the fixed 2-bit/16-deep stack. Adds run-time LIFO or FIFO mode, show-ahead output, simultaneous push/pop, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and synchronous clear. Sits between the command producer and its consumer wherever ordered buffering is needed.

## Interface
- DATA_WIDTH, 8, entry width in bits (≥1)
- DEPTH, 16, entries (≥2, need not be a power of 2)
- AF_LEVEL, DEPTH-2, ALMOST_FULL asserts when COUNT ≥ AF_LEVEL
- AE_LEVEL, 2, ALMOST_EMPTY asserts when COUNT ≤ AE_LEVEL
- CLK  in  1  single clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- CLEAR  in  1  synchronous empty; discards contents and clears error flags
- MODE  in  1  0 = LIFO, 1 = FIFO; sampled only while empty
- PUSH  in  1  write DATA_IN this cycle
- POP  in  1  consume DATA_OUT this cycle
- DATA_IN  in  DATA_WIDTH  write data
- DATA_OUT  out  DATA_WIDTH  show-ahead: current top (LIFO) or head (FIFO); 0 when empty
- COUNT  out  clog2(DEPTH+1)  occupied entries
- FULL, EMPTY  out  1  COUNT == DEPTH / COUNT == 0
- ALMOST_FULL, ALMOST_EMPTY  out  1  threshold flags
- OVERFLOW, UNDERFLOW  out  1  sticky error flags

## Operation
- State: storage array, COUNT, rd_ptr (FIFO head index), mode_q (latched mode).
- mode_q loads MODE on every cycle that EMPTY is 1 and no push is accepted; MODE changes while non-empty are ignored. rd_ptr is forced to 0 whenever mode_q loads.
- Write address: LIFO = COUNT; FIFO = (rd_ptr + COUNT) mod DEPTH. Top index (LIFO) = COUNT-1. All pointer wrap uses explicit compare against DEPTH-1, not bit truncation.
- Priority: CLEAR > push/pop. CLEAR: COUNT=0, rd_ptr=0, DATA_OUT=0, OVERFLOW=UNDERFLOW=0; PUSH/POP that cycle ignored.
- PUSH only: if !FULL, write, COUNT+1; if FULL, drop data, set OVERFLOW.
- POP only: if !EMPTY, COUNT-1 (FIFO: rd_ptr+1 wrap); if EMPTY, set UNDERFLOW, no state change.
- PUSH+POP, non-empty: LIFO overwrites top entry in place; FIFO writes tail and advances head. COUNT unchanged. Legal when FULL; no OVERFLOW.
- PUSH+POP, empty: push performed, pop ignored, UNDERFLOW set.
- DATA_OUT, every cycle, is the top/head entry of the post-update state: LIFO after push = DATA_IN; LIFO after replace = DATA_IN; LIFO after pop = entry at new COUNT-1; FIFO = entry at new rd_ptr (DATA_IN if pushing into empty). 0 when post-update COUNT is 0.
- Storage array is not reset; contents beyond COUNT are don't-care.

## Timing
- All outputs registered; every effect visible the cycle after the accepting edge. No combinational input-to-output path.
- Reset values: DATA_OUT=0, COUNT=0, EMPTY=1, FULL=0, ALMOST_EMPTY=1 (for AE_LEVEL ≥ 0), ALMOST_FULL=0, OVERFLOW=0, UNDERFLOW=0, mode_q=LIFO, rd_ptr=0.
- Reset mid-operation: immediate return to reset values; content lost.
- Throughput: one push and/or one pop per cycle, sustained, in both modes.
- Flags are derived from the next COUNT, so FULL/EMPTY/threshold flags are never one cycle stale.

## Structure
- Shared package stack_pkg: MODE_LIFO=1'b0, MODE_FIFO=1'b1 constants; existing clog2 function from clog2_function.vh.
- One sub-module stack_mem: DEPTH x DATA_WIDTH register file, one synchronous write port, two combinational read ports (current and next top/head addresses), no reset.
- mode_stack holds pointer/count logic, flag generation and DATA_OUT register.

## Test plan
- Reset, LIFO: push 0x11,0x22,0x33 -> DATA_OUT 0x11,0x22,0x33, COUNT 3; pop x3 -> DATA_OUT 0x22,0x11,0x00, EMPTY=1.
- FIFO (MODE=1 while empty): push 0xA0..0xA3 -> DATA_OUT stays 0xA0; pop x4 -> 0xA1,0xA2,0xA3,0x00; repeat 3*DEPTH pushes/pops to exercise rd_ptr wrap with DEPTH=5.
- Fill to DEPTH=16: FULL=1, ALMOST_FULL from COUNT 14; 17th push -> data dropped, OVERFLOW=1 and sticky until CLEAR; pop on empty -> UNDERFLOW=1.
- Simultaneous push+pop: LIFO full with top 0x0F, push 0x55+pop -> COUNT 16, DATA_OUT 0x55; FIFO full -> COUNT 16, head advances; on empty -> COUNT 1, UNDERFLOW=1.
- Toggle MODE with COUNT=3 -> mode unchanged; CLEAR with PUSH asserted -> COUNT 0, flags cleared, push ignored.
- Assert RST_N low mid-burst asynchronously (between edges) -> all outputs at reset values before next CLK edge.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the mode_stack storage block: buffer mode encoding and
// the ceiling-log2 helper used to size counters and addresses.
package stack_pkg;

    typedef enum logic {
        MODE_LIFO = 1'b0,
        MODE_FIFO = 1'b1
    } mode_e;

    // Bits needed to represent values 0 .. value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mode_stack_if.sv
// Producer/consumer-side signal bundle of mode_stack. The master modport is the
// side driving commands; the slave modport is the buffer itself.
interface mode_stack_if
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);

    localparam int CNT_W = clog2(DEPTH + 1);

    logic                  CLEAR;
    logic                  MODE;
    logic                  PUSH;
    logic                  POP;
    logic [DATA_WIDTH-1:0] DATA_IN;
    logic [DATA_WIDTH-1:0] DATA_OUT;
    logic [CNT_W-1:0]      COUNT;
    logic                  FULL;
    logic                  EMPTY;
    logic                  ALMOST_FULL;
    logic                  ALMOST_EMPTY;
    logic                  OVERFLOW;
    logic                  UNDERFLOW;

    modport master (
        output CLEAR, MODE, PUSH, POP, DATA_IN,
        input  DATA_OUT, COUNT, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  CLEAR, MODE, PUSH, POP, DATA_IN,
        output DATA_OUT, COUNT, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW
    );

endinterface

// File: rtl/stack_mem.sv
// DEPTH x DATA_WIDTH register file: one synchronous write port and two
// combinational read ports (current and next top/head entry).
module stack_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr_cur,
    output logic [DATA_WIDTH-1:0] rdata_cur,
    input  logic [ADDR_W-1:0]     raddr_nxt,
    output logic [DATA_WIDTH-1:0] rdata_nxt
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; validity is tracked by the count, and a
    // reset port here would turn a plain register file into DEPTH reset flops.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Addresses past DEPTH-1 only occur for unused read ports on non-power-of-2 depths.
    assign rdata_cur = (int'(raddr_cur) < DEPTH) ? mem[raddr_cur] : '0;
    assign rdata_nxt = (int'(raddr_nxt) < DEPTH) ? mem[raddr_nxt] : '0;

endmodule

// File: rtl/mode_stack.sv
// Run-time selectable LIFO/FIFO buffer with show-ahead output, occupancy count,
// threshold flags and sticky overflow/underflow; all outputs registered.
module mode_stack
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input logic         CLK,
    input logic         RST_N,
    mode_stack_if.slave bus
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int CNT_W  = clog2(DEPTH + 1);
    localparam int SUM_W  = CNT_W + 1;

    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  AF_C     = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0]  AE_C     = CNT_W'(AE_LEVEL);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [SUM_W-1:0]  DEPTH_X  = SUM_W'(DEPTH);
    localparam logic [SUM_W-1:0]  LAST_X   = SUM_W'(DEPTH - 1);

    logic [CNT_W-1:0]      count_q,    count_d;
    logic [ADDR_W-1:0]     rd_ptr_q,   rd_ptr_d;
    mode_e                 mode_q,     mode_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  ovf_q,      ovf_d;
    logic                  udf_q,      udf_d;
    logic                  full_q,     full_d;
    logic                  empty_q,    empty_d;
    logic                  af_q,       af_d;
    logic                  ae_q,       ae_d;

    logic                  is_empty, is_full;
    logic                  do_push, do_pop;
    logic [SUM_W-1:0]      tail_sum;
    logic [ADDR_W-1:0]     tail_idx, top_idx, below_top_idx, ptr_inc;
    logic [ADDR_W-1:0]     rd_addr_cur, rd_addr_nxt;
    logic [DATA_WIDTH-1:0] rdata_cur, rdata_nxt;
    logic                  we;
    logic [ADDR_W-1:0]     waddr;

    // Index arithmetic; wrap uses an explicit compare so non-power-of-2 depths work.
    assign is_empty      = (count_q == '0);
    assign is_full       = (count_q == DEPTH_C);
    assign tail_sum      = SUM_W'(rd_ptr_q) + SUM_W'(count_q);
    assign tail_idx      = ADDR_W'((tail_sum > LAST_X) ? (tail_sum - DEPTH_X) : tail_sum);
    assign top_idx       = ADDR_W'(count_q - CNT_W'(1));
    assign below_top_idx = ADDR_W'(count_q - CNT_W'(2));
    assign ptr_inc       = (rd_ptr_q == LAST_IDX) ? '0 : (rd_ptr_q + ADDR_W'(1));
    assign rd_addr_cur   = (mode_q == MODE_LIFO) ? top_idx       : rd_ptr_q;
    assign rd_addr_nxt   = (mode_q == MODE_LIFO) ? below_top_idx : ptr_inc;

    // A push is refused only when full with no simultaneous pop.
    assign do_push = !bus.CLEAR && bus.PUSH && (!is_full || bus.POP);
    assign do_pop  = !bus.CLEAR && bus.POP && !is_empty;

    stack_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk       (CLK),
        .we        (we),
        .waddr     (waddr),
        .wdata     (bus.DATA_IN),
        .raddr_cur (rd_addr_cur),
        .rdata_cur (rdata_cur),
        .raddr_nxt (rd_addr_nxt),
        .rdata_nxt (rdata_nxt)
    );

    // NOTE: every signal gets its default before any branch, so no path
    // leaves a value unassigned and no latch can be inferred.
    always_comb begin
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        mode_d     = mode_q;
        data_out_d = data_out_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        we         = 1'b0;
        waddr      = tail_idx;

        if (is_empty && !do_push) begin
            mode_d   = mode_e'(bus.MODE);
            rd_ptr_d = '0;
        end

        if (bus.CLEAR) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            data_out_d = '0;
            ovf_d      = 1'b0;
            udf_d      = 1'b0;
        end else begin
            if (bus.PUSH && !bus.POP && is_full) ovf_d = 1'b1;
            if (bus.POP && is_empty)             udf_d = 1'b1;

            if (do_push && do_pop) begin
                we = 1'b1;
                if (mode_q == MODE_LIFO) begin
                    waddr      = top_idx;
                    data_out_d = bus.DATA_IN;
                end else begin
                    rd_ptr_d   = ptr_inc;
                    // With a single entry the new head is the word being written.
                    data_out_d = (count_q == CNT_W'(1)) ? bus.DATA_IN : rdata_nxt;
                end
            end else if (do_push) begin
                we      = 1'b1;
                count_d = count_q + CNT_W'(1);
                if (mode_q == MODE_LIFO) begin
                    waddr      = ADDR_W'(count_q);
                    data_out_d = bus.DATA_IN;
                end else begin
                    data_out_d = is_empty ? bus.DATA_IN : rdata_cur;
                end
            end else if (do_pop) begin
                count_d    = count_q - CNT_W'(1);
                data_out_d = (count_q == CNT_W'(1)) ? '0 : rdata_nxt;
                if (mode_q == MODE_FIFO) rd_ptr_d = ptr_inc;
            end else begin
                data_out_d = is_empty ? '0 : rdata_cur;
            end
        end

        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            mode_q     <= MODE_LIFO;
            data_out_q <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            mode_q     <= mode_d;
            data_out_q <= data_out_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
        end
    end

    assign bus.DATA_OUT     = data_out_q;
    assign bus.COUNT        = count_q;
    assign bus.FULL         = full_q;
    assign bus.EMPTY        = empty_q;
    assign bus.ALMOST_FULL  = af_q;
    assign bus.ALMOST_EMPTY = ae_q;
    assign bus.OVERFLOW     = ovf_q;
    assign bus.UNDERFLOW    = udf_q;

endmodule

// File: tb/tb_mode_stack.sv
// Directed bench for mode_stack: a DEPTH=16 instance for LIFO/FIFO/flag behaviour
// and a DEPTH=5 instance for FIFO head wrap-around.
module tb_mode_stack;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    mode_stack_if #(.DATA_WIDTH(8), .DEPTH(16)) bus16 ();
    mode_stack_if #(.DATA_WIDTH(8), .DEPTH(5))  bus5 ();

    mode_stack #(.DATA_WIDTH(8), .DEPTH(16)) dut16 (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus16)
    );

    mode_stack #(.DATA_WIDTH(8), .DEPTH(5)) dut5 (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op16(input logic push, input logic pop, input logic [7:0] din);
        bus16.PUSH    = push;
        bus16.POP     = pop;
        bus16.DATA_IN = din;
        tick();
        bus16.PUSH = 1'b0;
        bus16.POP  = 1'b0;
    endtask

    task automatic op5(input logic push, input logic pop, input logic [7:0] din);
        bus5.PUSH    = push;
        bus5.POP     = pop;
        bus5.DATA_IN = din;
        tick();
        bus5.PUSH = 1'b0;
        bus5.POP  = 1'b0;
    endtask

    task automatic expect16(input string tag, input logic [7:0] data, input int count);
        check({tag, " data"},  32'(bus16.DATA_OUT), 32'(data));
        check({tag, " count"}, 32'(bus16.COUNT),    count);
    endtask

    task automatic expect_reset16(input string tag);
        expect16(tag, 8'h00, 0);
        check({tag, " empty"}, 32'(bus16.EMPTY),        1);
        check({tag, " full"},  32'(bus16.FULL),         0);
        check({tag, " ae"},    32'(bus16.ALMOST_EMPTY), 1);
        check({tag, " af"},    32'(bus16.ALMOST_FULL),  0);
        check({tag, " ovf"},   32'(bus16.OVERFLOW),     0);
        check({tag, " udf"},   32'(bus16.UNDERFLOW),    0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        {bus16.CLEAR, bus16.MODE, bus16.PUSH, bus16.POP} = 4'b0000;
        {bus5.CLEAR, bus5.MODE, bus5.PUSH, bus5.POP}     = 4'b0000;
        bus16.DATA_IN = 8'h00;
        bus5.DATA_IN  = 8'h00;
        tick();
        tick();
        expect_reset16("reset");
        rst_n = 1'b1;
        tick();

        // LIFO push/pop ordering
        op16(1'b1, 1'b0, 8'h11); expect16("lifo push1", 8'h11, 1);
        op16(1'b1, 1'b0, 8'h22); expect16("lifo push2", 8'h22, 2);
        op16(1'b1, 1'b0, 8'h33); expect16("lifo push3", 8'h33, 3);
        check("lifo cnt3 ae", 32'(bus16.ALMOST_EMPTY), 0);

        // MODE change while non-empty must be ignored: pops stay LIFO
        bus16.MODE = 1'b1;
        tick();
        expect16("mode ignored idle", 8'h33, 3);
        op16(1'b0, 1'b1, 8'h00); expect16("lifo pop1", 8'h22, 2);
        check("lifo cnt2 ae", 32'(bus16.ALMOST_EMPTY), 1);
        op16(1'b0, 1'b1, 8'h00); expect16("lifo pop2", 8'h11, 1);
        op16(1'b0, 1'b1, 8'h00); expect16("lifo pop3", 8'h00, 0);
        check("lifo empty", 32'(bus16.EMPTY), 1);

        // FIFO: MODE=1 is loaded on the idle empty cycle
        tick();
        for (int i = 0; i < 4; i++) begin
            op16(1'b1, 1'b0, 8'(8'hA0 + i));
            expect16("fifo push", 8'hA0, i + 1);
        end
        op16(1'b0, 1'b1, 8'h00); expect16("fifo pop1", 8'hA1, 3);
        op16(1'b0, 1'b1, 8'h00); expect16("fifo pop2", 8'hA2, 2);
        op16(1'b0, 1'b1, 8'h00); expect16("fifo pop3", 8'hA3, 1);
        op16(1'b0, 1'b1, 8'h00); expect16("fifo pop4", 8'h00, 0);

        // Underflow, clear, push+pop on empty, single-entry replace
        op16(1'b0, 1'b1, 8'h00);
        check("udf on empty", 32'(bus16.UNDERFLOW), 1);
        expect16("udf no change", 8'h00, 0);
        bus16.CLEAR = 1'b1; tick(); bus16.CLEAR = 1'b0;
        check("clear udf", 32'(bus16.UNDERFLOW), 0);
        op16(1'b1, 1'b1, 8'h77);
        expect16("pushpop empty", 8'h77, 1);
        check("pushpop empty udf", 32'(bus16.UNDERFLOW), 1);
        op16(1'b1, 1'b1, 8'h78);
        expect16("fifo replace cnt1", 8'h78, 1);
        bus16.CLEAR = 1'b1;
        op16(1'b1, 1'b0, 8'h99);
        bus16.CLEAR = 1'b0;
        expect_reset16("clear with push");

        // FIFO fill to full with threshold flags
        tick();
        for (int i = 0; i < 16; i++) begin
            op16(1'b1, 1'b0, 8'(8'h10 + i));
            expect16("fifo fill", 8'h10, i + 1);
            check("fifo fill af",   32'(bus16.ALMOST_FULL), (i + 1 >= 14) ? 1 : 0);
            check("fifo fill full", 32'(bus16.FULL),        (i + 1 == 16) ? 1 : 0);
        end
        op16(1'b1, 1'b1, 8'h55);
        expect16("fifo full pushpop", 8'h11, 16);
        check("fifo full pushpop ovf", 32'(bus16.OVERFLOW), 0);
        op16(1'b1, 1'b0, 8'h66);
        expect16("fifo overflow drop", 8'h11, 16);
        check("fifo overflow flag", 32'(bus16.OVERFLOW), 1);
        for (int k = 1; k <= 16; k++) begin
            op16(1'b0, 1'b1, 8'h00);
            expect16("fifo drain", (k < 15) ? 8'(8'h11 + k) : ((k == 15) ? 8'h55 : 8'h00), 16 - k);
        end
        check("ovf sticky", 32'(bus16.OVERFLOW), 1);
        bus16.CLEAR = 1'b1; tick(); bus16.CLEAR = 1'b0;
        check("clear ovf", 32'(bus16.OVERFLOW), 0);

        // LIFO full: replace top, overflow, pop below
        bus16.MODE = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) op16(1'b1, 1'b0, 8'(i));
        expect16("lifo full", 8'h0F, 16);
        check("lifo full flag", 32'(bus16.FULL), 1);
        op16(1'b1, 1'b1, 8'h55);
        expect16("lifo replace", 8'h55, 16);
        check("lifo replace ovf", 32'(bus16.OVERFLOW), 0);
        op16(1'b1, 1'b0, 8'h66);
        expect16("lifo overflow drop", 8'h55, 16);
        check("lifo overflow flag", 32'(bus16.OVERFLOW), 1);
        op16(1'b0, 1'b1, 8'h00); expect16("lifo full pop1", 8'h0E, 15);
        op16(1'b0, 1'b1, 8'h00); expect16("lifo full pop2", 8'h0D, 14);

        // Asynchronous reset between edges during a push burst
        bus16.PUSH    = 1'b1;
        bus16.DATA_IN = 8'hA5;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        expect_reset16("async reset");
        bus16.PUSH = 1'b0;
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        expect_reset16("after reset");

        // DEPTH=5 FIFO: head pointer wraps three times under sustained push+pop
        bus5.MODE = 1'b1;
        tick();
        op5(1'b1, 1'b0, 8'h40);
        op5(1'b1, 1'b0, 8'h41);
        for (int i = 0; i < 15; i++) begin
            op5(1'b1, 1'b1, 8'(8'h42 + i));
            check("d5 wrap data",  32'(bus5.DATA_OUT), 32'(8'h41 + i));
            check("d5 wrap count", 32'(bus5.COUNT),    2);
        end
        op5(1'b1, 1'b0, 8'h51);
        op5(1'b1, 1'b0, 8'h52);
        op5(1'b1, 1'b0, 8'h53);
        check("d5 full",      32'(bus5.FULL),     1);
        check("d5 full head", 32'(bus5.DATA_OUT), 32'h4F);
        op5(1'b1, 1'b1, 8'h54);
        check("d5 full pushpop", 32'(bus5.DATA_OUT), 32'h50);
        check("d5 full count",   32'(bus5.COUNT),    5);
        for (int k = 0; k < 5; k++) begin
            op5(1'b0, 1'b1, 8'h00);
            check("d5 drain", 32'(bus5.DATA_OUT), (k < 4) ? 32'(8'h51 + k) : 32'h00);
        end
        check("d5 empty", 32'(bus5.EMPTY), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
